regfile_access_ctrl: RTL and testbench

Controller that owns the register file's single write port and its debug read port.
- After reset, sequences a clear of all 32 registers (x0..x31) before releasing the core.
- Arbitrates the write port between core writeback and a debug host on a valid/ready request/response interface.
- Drops every write to x0.
- A starvation counter guarantees pending debug writes complete even under continuous core writeback.

---
 rtl/regfile_ctrl_pkg.sv | 26 ++
 rtl/regfile_init_seq.sv | 30 +++
 rtl/regfile_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register file access controller.
// Imported by the controller top and its clear sequencer.
package regfile_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_X0   = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_LAST =
    REG_ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    RD      = 3'd2,
    WR_WAIT = 3'd3,
    RSP     = 3'd4
  } state_t;

  function automatic logic is_live_reg(
    input logic [REG_ADDR_W-1:0] addr
  );
    return addr != REG_X0;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks x0..x31 once, then idles.
// Restarts only through its asynchronous active-low reset.
module regfile_init_seq
  import regfile_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [REG_ADDR_W-1:0] clear_addr,
  output logic                  clear_active
);

  logic done_q;

  // Step the clear address once per cycle until the last register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_addr <= '0;
      done_q     <= 1'b0;
    end else if (!done_q) begin
      if (clear_addr == REG_LAST) begin
        done_q <= 1'b1;
      end else begin
        clear_addr <= clear_addr + 1'b1;
      end
    end
  end

  assign clear_active = !done_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register file write-port arbiter and debug access controller.
// Clears the file after reset, then shares the port core/debug.
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_we,
  input  logic [REG_ADDR_W-1:0] core_rd,
  input  logic [WIDTH-1:0]      core_wdata,
  output logic                  core_stall,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_write,
  input  logic [REG_ADDR_W-1:0] dbg_req_addr,
  input  logic [WIDTH-1:0]      dbg_req_wdata,
  output logic                  dbg_rsp_valid,
  input  logic                  dbg_rsp_ready,
  output logic [WIDTH-1:0]      dbg_rsp_data,
  output logic                  dbg_rsp_err,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_dest_select,
  output logic [WIDTH-1:0]      rf_data,
  output logic [REG_ADDR_W-1:0] rf_debug_select,
  input  logic [WIDTH-1:0]      rf_debug_out,
  output logic                  init_done
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [REG_ADDR_W-1:0] clear_addr;
  logic                  clear_active;
  logic                  core_busy;
  logic                  starved;
  logic                  grant;

  regfile_init_seq u_init_seq (
    .clk          (clk),
    .rst_n        (reset),
    .clear_addr   (clear_addr),
    .clear_active (clear_active)
  );

  assign init_done = !clear_active;

  assign core_busy = core_we && is_live_reg(core_rd);
  assign starved   = (wait_cnt == LIMIT);
  assign grant     = (state == WR_WAIT)
                  && (!core_busy || starved);

  assign dbg_req_ready   = reset && (state == IDLE);
  assign rf_debug_select = addr_q;

  // Write-port mux: clear, granted debug write, else core writeback.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_dest_select  = core_rd;
    rf_data         = core_wdata;
    core_stall      = 1'b0;
    if (!reset) begin
      core_stall = 1'b1;
    end else if (state == INIT) begin
      rf_write_enable = 1'b1;
      rf_dest_select  = clear_addr;
      rf_data         = '0;
      core_stall      = 1'b1;
    end else if (grant) begin
      rf_write_enable = is_live_reg(addr_q);
      rf_dest_select  = addr_q;
      rf_data         = wdata_q;
      core_stall      = core_busy;
    end else begin
      rf_write_enable = core_busy;
    end
  end

  // Debug transaction FSM with registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= INIT;
      wait_cnt      <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      dbg_rsp_data  <= '0;
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_err   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clear_addr == REG_LAST) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (dbg_req_valid) begin
            addr_q  <= dbg_req_addr;
            wdata_q <= dbg_req_wdata;
            if (dbg_req_write) begin
              wait_cnt <= '0;
              state    <= WR_WAIT;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          dbg_rsp_data  <= rf_debug_out;
          dbg_rsp_err   <= 1'b0;
          dbg_rsp_valid <= 1'b1;
          state         <= RSP;
        end
        WR_WAIT: begin
          if (grant) begin
            dbg_rsp_data  <= wdata_q;
            dbg_rsp_err   <= !is_live_reg(addr_q);
            dbg_rsp_valid <= 1'b1;
            state         <= RSP;
          end else if (!starved) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RSP: begin
          if (dbg_rsp_ready) begin
            dbg_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a falling-edge
// register file model; directed vectors, expected values by hand.
module tb_regfile_access_ctrl;

  logic        clk;
  logic        reset;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wdata;
  logic        core_stall;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_write;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_data;
  logic        dbg_rsp_err;
  logic        rf_write_enable;
  logic [4:0]  rf_dest_select;
  logic [31:0] rf_data;
  logic [4:0]  rf_debug_select;
  logic [31:0] rf_debug_out;
  logic        init_done;

  int total = 0;
  int bad   = 0;
  int x0_wr = 0;

  logic [32:0] exp_q[$];
  logic [31:0] rf_mem[32];

  regfile_access_ctrl #(
    .WIDTH        (32),
    .STARVE_LIMIT (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .core_we         (core_we),
    .core_rd         (core_rd),
    .core_wdata      (core_wdata),
    .core_stall      (core_stall),
    .dbg_req_valid   (dbg_req_valid),
    .dbg_req_ready   (dbg_req_ready),
    .dbg_req_write   (dbg_req_write),
    .dbg_req_addr    (dbg_req_addr),
    .dbg_req_wdata   (dbg_req_wdata),
    .dbg_rsp_valid   (dbg_rsp_valid),
    .dbg_rsp_ready   (dbg_rsp_ready),
    .dbg_rsp_data    (dbg_rsp_data),
    .dbg_rsp_err     (dbg_rsp_err),
    .rf_write_enable (rf_write_enable),
    .rf_dest_select  (rf_dest_select),
    .rf_data         (rf_data),
    .rf_debug_select (rf_debug_select),
    .rf_debug_out    (rf_debug_out),
    .init_done       (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: garbage at power-up, writes on falling edge.
  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hBAD0_0000 | i;
    forever begin
      @(negedge clk);
      if (rf_write_enable) rf_mem[rf_dest_select] = rf_data;
    end
  end

  assign rf_debug_out = rf_mem[rf_debug_select];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (reset && dbg_rsp_valid && dbg_rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %h want none",
                 {dbg_rsp_err, dbg_rsp_data});
      end else begin
        chk("rsp", {dbg_rsp_err, dbg_rsp_data}, exp_q.pop_front());
      end
    end
    if (reset && init_done && rf_write_enable
        && rf_dest_select == 5'd0)
      x0_wr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_issue(input bit wr,
                           input logic [4:0] a,
                           input logic [31:0] d);
    bit got;
    got = 1'b0;
    dbg_req_valid = 1'b1;
    dbg_req_write = wr;
    dbg_req_addr  = a;
    dbg_req_wdata = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = dbg_req_ready;
      step();
    end
    dbg_req_valid = 1'b0;
    if (!got) chk("req_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_rsp(output int lat);
    bit seen;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dbg_rsp_valid) begin
        seen = 1'b1;
        lat = i;
      end
      step();
    end
    if (!seen) chk("rsp_timeout", 64'(seen), 64'd1);
  endtask

  task automatic do_read(input logic [4:0] a,
                         input logic [31:0] exp,
                         output int lat);
    exp_q.push_back({1'b0, exp});
    dbg_issue(1'b0, a, 32'h0);
    wait_rsp(lat);
  endtask

  task automatic do_write(input logic [4:0] a,
                          input logic [31:0] d,
                          output int lat);
    exp_q.push_back({a == 5'd0, d});
    dbg_issue(1'b1, a, d);
    wait_rsp(lat);
  endtask

  task automatic init_check(input string tag);
    int e;
    e = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (rf_write_enable !== 1'b1 || rf_dest_select !== 5'(i)
          || rf_data !== 32'h0 || core_stall !== 1'b1
          || init_done !== 1'b0 || dbg_req_ready !== 1'b0)
        e++;
    end
    chk({tag, "_clear_errs"}, 64'(e), 64'd0);
    @(negedge clk);
    chk({tag, "_init_done"}, 64'(init_done), 64'd1);
    chk({tag, "_stall_off"}, 64'(core_stall), 64'd0);
    chk({tag, "_req_ready"}, 64'(dbg_req_ready), 64'd1);
    step();
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_rf_we"}, 64'(rf_write_enable), 64'd0);
    chk({tag, "_stall"}, 64'(core_stall), 64'd1);
    chk({tag, "_req_ready"}, 64'(dbg_req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(dbg_rsp_valid), 64'd0);
    chk({tag, "_rsp_err"}, 64'(dbg_rsp_err), 64'd0);
    chk({tag, "_rsp_data"}, 64'(dbg_rsp_data), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
    chk({tag, "_dbg_sel"}, 64'(rf_debug_select), 64'd0);
  endtask

  initial begin
    int lat;
    int stalls;
    int stall_k;
    logic stall_ok;
    reset         = 1'b0;
    core_we       = 1'b0;
    core_rd       = 5'd0;
    core_wdata    = 32'h0;
    dbg_req_valid = 1'b0;
    dbg_req_write = 1'b0;
    dbg_req_addr  = 5'd0;
    dbg_req_wdata = 32'h0;
    dbg_rsp_ready = 1'b1;

    #3;
    reset_values("por");
    step();
    step();
    reset = 1'b1;
    init_check("init1");

    do_read(5'd7, 32'h0, lat);

    core_we    = 1'b1;
    core_rd    = 5'd5;
    core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("core_we", 64'(rf_write_enable), 64'd1);
    chk("core_dest", 64'(rf_dest_select), 64'd5);
    chk("core_nostall", 64'(core_stall), 64'd0);
    step();
    core_we = 1'b0;
    do_read(5'd5, 32'hDEADBEEF, lat);
    chk("rd_latency", 64'(lat), 64'd2);

    core_we    = 1'b1;
    core_rd    = 5'd3;
    core_wdata = 32'h0000_0033;
    step();
    exp_q.push_back({1'b0, 32'h12345678});
    dbg_issue(1'b1, 5'd9, 32'h12345678);
    stalls   = 0;
    stall_k  = -1;
    stall_ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (core_stall) begin
        stalls++;
        if (stall_k < 0) stall_k = k;
        stall_ok = rf_write_enable && rf_dest_select == 5'd9
                && rf_data == 32'h12345678;
      end
      step();
    end
    core_we = 1'b0;
    chk("stall_pulses", 64'(stalls), 64'd1);
    chk("stall_cycle", 64'(stall_k), 64'd8);
    chk("stall_dbg_write", 64'(stall_ok), 64'd1);
    do_read(5'd9, 32'h12345678, lat);
    do_read(5'd3, 32'h0000_0033, lat);

    core_we    = 1'b1;
    core_rd    = 5'd0;
    core_wdata = 32'h0000_FFFF;
    @(negedge clk);
    chk("core_x0_drop", 64'(rf_write_enable), 64'd0);
    step();
    do_write(5'd0, 32'h0000_AAAA, lat);
    chk("wr_x0_latency", 64'(lat), 64'd2);
    core_we = 1'b0;
    do_read(5'd0, 32'h0, lat);

    do_write(5'd2, 32'h2222_0002, lat);
    dbg_rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h2222_0002});
    dbg_issue(1'b0, 5'd2, 32'h0);
    @(negedge clk);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(dbg_rsp_valid), 64'd1);
      chk("hold_data", 64'(dbg_rsp_data), 64'h2222_0002);
      chk("hold_ready", 64'(dbg_req_ready), 64'd0);
      step();
    end
    dbg_rsp_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("back_idle_ready", 64'(dbg_req_ready), 64'd1);
    chk("back_idle_valid", 64'(dbg_rsp_valid), 64'd0);
    step();

    core_we    = 1'b1;
    core_rd    = 5'd3;
    core_wdata = 32'h0000_0033;
    dbg_issue(1'b1, 5'd4, 32'h0000_4444);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    reset_values("midrst");
    core_we = 1'b0;
    step();
    step();
    reset = 1'b1;
    init_check("init2");
    do_read(5'd4, 32'h0, lat);
    do_read(5'd9, 32'h0, lat);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("x0_writes", 64'(x0_wr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
